main_mem_responder: RTL and testbench
=====================================

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_BLOCKS, default 256: number of 64-byte blocks stored; power of two, at least 2.
REQ-002 SHALL have parameter READ_LATENCY, default 4: cycles from request acceptance to the read mem_ready pulse; at least 1.
REQ-003 SHALL have parameter WRITE_LATENCY, default 2: cycles from request acceptance to the write mem_ready pulse; at least 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port mem_addr, input, 32 bits: byte address of the request.
REQ-007 SHALL have port mem_wdata, input, 32 bits: write word.
REQ-008 SHALL have port mem_read_req, input, 1 bit: block-read request.
REQ-009 SHALL have port mem_write_req, input, 1 bit: word-write request.
REQ-010 SHALL have port mem_rdata, output, 512 bits: read block; word w occupies bits [32w+31:32w].
REQ-011 SHALL have port mem_ready, output, 1 bit: completion pulse.
REQ-012 SHALL have port busy, output, 1 bit: high while a request is in service.
REQ-013 SHALL have port protocol_err, output, 1 bit: sticky error flag.

Function
REQ-014 SHALL decode each address as block = mem_addr[6+log2(DEPTH_BLOCKS)-1:6] and word = mem_addr[5:2]; higher address bits ignored (wrap modulo DEPTH_BLOCKS); mem_addr[1:0] ignored.
REQ-015 SHALL implement an FSM with states IDLE, READ_BUSY, WRITE_BUSY and RESPOND.
REQ-016 SHALL accept requests only in IDLE; on acceptance, latch address and data, load the latency counter with LATENCY-1, and enter READ_BUSY or WRITE_BUSY.
REQ-017 SHALL decrement the counter each cycle in a BUSY state and go to RESPOND when it reaches 0.
REQ-018 SHALL, in RESPOND, drive mem_ready high for exactly one cycle and then return to IDLE.
REQ-019 SHALL make the mem_ready pulse occur exactly LATENCY cycles after the acceptance edge, with LATENCY = 1 giving a pulse on the next cycle.
REQ-020 SHALL, on a read, register the whole block into mem_rdata on the cycle mem_ready rises, and hold mem_rdata stable until the next read completes.
REQ-021 SHALL, on a write, update only the addressed 32-bit word on the mem_ready cycle; the other 15 words are unchanged.
REQ-022 SHALL, when read and write requests are both high in IDLE, service the read, drop the write, and set protocol_err.
REQ-023 SHALL ignore any request arriving while not in IDLE (no queuing) and set protocol_err.
REQ-024 SHALL keep protocol_err set until reset.
REQ-025 SHALL allow a request in the cycle right after the mem_ready pulse (IDLE) to be accepted normally, giving back-to-back service.
REQ-026 SHALL drive busy high exactly when the state is not IDLE.
REQ-027 SHALL, on a read that follows a completed write to the same block, return the written word.

Reset
REQ-028 SHALL, while rst_n is low, hold state IDLE, counter 0, mem_ready 0, busy 0, protocol_err 0 and mem_rdata all-zero.
REQ-029 SHALL, on reset mid-operation, abandon the in-flight request with no storage update and no mem_ready pulse.
REQ-030 SHALL NOT reset storage contents; they are undefined until written, and the bench preloads storage through hierarchical access.

Structure
REQ-031 SHALL take OFFSET_BITS=6, WORD_BITS=32, BLOCK_BITS=512 and the FSM state encoding from a shared package, also used by the cache controller.
REQ-032 SHALL hold storage in one sub-module, main_mem_block_ram: one 512-bit read port and one write port with 16 per-word write enables.

Verification
REQ-033 SHALL cover: preload block 5 with word k = k, read at 0x0000_0140 -> mem_ready exactly 4 cycles later, mem_rdata word 3 = 0x3.
REQ-034 SHALL cover: write 0xDEAD_BEEF to 0x0000_0148, then read 0x0000_0140 -> ready 2 cycles after the write, word 2 = 0xDEAD_BEEF, other words unchanged.
REQ-035 SHALL cover: read and write both high in IDLE -> read serviced, storage unchanged, protocol_err = 1.
REQ-036 SHALL cover: a new read pulsed during READ_BUSY -> ignored, a single mem_ready pulse, protocol_err = 1.
REQ-037 SHALL cover: rst_n low 2 cycles after a read request -> no mem_ready; busy = 0 and protocol_err = 0 after release.
REQ-038 SHALL cover: read at 0x0001_0140 with DEPTH_BLOCKS = 256 -> same data as 0x0000_0140 (wrap).

Source files
------------

// File: rtl/main_mem_responder_pkg.sv
// Shared main-memory definitions: block geometry, FSM encoding, request payload.
package main_mem_responder_pkg;

    localparam int unsigned OFFSET_BITS     = 6;
    localparam int unsigned WORD_BITS       = 32;
    localparam int unsigned BLOCK_BITS      = 512;
    localparam int unsigned WORDS_PER_BLOCK = BLOCK_BITS / WORD_BITS;
    localparam int unsigned WORD_SEL_BITS   = OFFSET_BITS - 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_BUSY  = 2'd1,
        WRITE_BUSY = 2'd2,
        RESPOND    = 2'd3
    } mem_state_e;

    // Word-write payload captured when a request is accepted
    typedef struct packed {
        logic [WORD_SEL_BITS-1:0] word;
        logic [WORD_BITS-1:0]     wdata;
    } mem_wr_word_t;

    // One-hot word enable for a word index within a block
    function automatic logic [WORDS_PER_BLOCK-1:0] word_onehot(input logic [WORD_SEL_BITS-1:0] sel);
        return WORDS_PER_BLOCK'(1) << sel;
    endfunction

endpackage

// File: rtl/main_mem_block_ram.sv
// Block storage: full-block asynchronous read port, per-word-enabled write port.
module main_mem_block_ram
    import main_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_BLOCKS    = 256,
    parameter int unsigned BLOCK_ADDR_BITS = $clog2(DEPTH_BLOCKS)
) (
    input  logic                       clk,
    input  logic [BLOCK_ADDR_BITS-1:0] rd_block,
    output logic [BLOCK_BITS-1:0]      rd_data_c,
    input  logic [WORDS_PER_BLOCK-1:0] wr_word_en,
    input  logic [BLOCK_ADDR_BITS-1:0] wr_block,
    input  logic [BLOCK_BITS-1:0]      wr_data
);

    logic [BLOCK_BITS-1:0] mem [DEPTH_BLOCKS];

    assign rd_data_c = mem[rd_block];

    // Word-granular write; contents are intentionally never reset
    always_ff @(posedge clk) begin
        for (int w = 0; w < int'(WORDS_PER_BLOCK); w++) begin
            if (wr_word_en[w]) begin
                mem[wr_block][w*WORD_BITS +: WORD_BITS] <= wr_data[w*WORD_BITS +: WORD_BITS];
            end
        end
    end

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory responder: block reads, word writes, one request at a time.
module main_mem_responder
    import main_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_BLOCKS  = 256,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic                  mem_read_req,
    input  logic                  mem_write_req,
    output logic [BLOCK_BITS-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  busy,
    output logic                  protocol_err
);

    localparam int unsigned BLOCK_ADDR_BITS = $clog2(DEPTH_BLOCKS);
    localparam int unsigned MAX_LAT  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CNT_BITS = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    mem_state_e                 state, state_next;
    logic [CNT_BITS-1:0]        cnt, cnt_next;
    logic [BLOCK_ADDR_BITS-1:0] req_block;
    mem_wr_word_t               req_wr;
    logic                       accept;
    logic                       ready_next;
    logic                       busy_next;
    logic                       err_next;
    logic                       load_rdata;
    logic                       ram_we;
    logic [BLOCK_BITS-1:0]      ram_rdata_c;
    logic                       any_req;
    logic                       unused_addr_bits;

    assign any_req          = mem_read_req | mem_write_req;
    assign unused_addr_bits = ^{mem_addr[31:OFFSET_BITS+BLOCK_ADDR_BITS], mem_addr[1:0]};

    // Next-state, counter and registered-output intent
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        ready_next = 1'b0;
        err_next   = protocol_err;
        load_rdata = 1'b0;
        ram_we     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read_req) begin
                    accept     = 1'b1;
                    state_next = READ_BUSY;
                    cnt_next   = CNT_BITS'(READ_LATENCY - 1);
                    if (mem_write_req) err_next = 1'b1;
                end else if (mem_write_req) begin
                    accept     = 1'b1;
                    state_next = WRITE_BUSY;
                    cnt_next   = CNT_BITS'(WRITE_LATENCY - 1);
                end
            end
            READ_BUSY: begin
                if (any_req) err_next = 1'b1;
                if (cnt == '0) begin
                    state_next = RESPOND;
                    ready_next = 1'b1;
                    load_rdata = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_BITS'(1);
                end
            end
            WRITE_BUSY: begin
                if (any_req) err_next = 1'b1;
                if (cnt == '0) begin
                    state_next = RESPOND;
                    ready_next = 1'b1;
                    ram_we     = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_BITS'(1);
                end
            end
            RESPOND: begin
                if (any_req) err_next = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    // State, request latch and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            req_block    <= '0;
            req_wr       <= '0;
            mem_ready    <= 1'b0;
            busy         <= 1'b0;
            protocol_err <= 1'b0;
            mem_rdata    <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            mem_ready    <= ready_next;
            busy         <= busy_next;
            protocol_err <= err_next;
            if (accept) begin
                req_block    <= mem_addr[OFFSET_BITS +: BLOCK_ADDR_BITS];
                req_wr.word  <= mem_addr[OFFSET_BITS-1:2];
                req_wr.wdata <= mem_wdata;
            end
            if (load_rdata) mem_rdata <= ram_rdata_c;
        end
    end

    main_mem_block_ram #(
        .DEPTH_BLOCKS    (DEPTH_BLOCKS),
        .BLOCK_ADDR_BITS (BLOCK_ADDR_BITS)
    ) u_ram (
        .clk        (clk),
        .rd_block   (req_block),
        .rd_data_c  (ram_rdata_c),
        .wr_word_en (ram_we ? word_onehot(req_wr.word) : '0),
        .wr_block   (req_block),
        .wr_data    ({WORDS_PER_BLOCK{req_wr.wdata}})
    );

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder with a response scoreboard and storage model.
module tb_main_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned RL    = 4;
    localparam int unsigned WL    = 2;

    typedef struct {
        bit           is_read;
        int unsigned  due;
        logic [511:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_read_req;
    logic         mem_write_req;
    logic [511:0] mem_rdata;
    logic         mem_ready;
    logic         busy;
    logic         protocol_err;

    int unsigned  cyc = 0;
    int           checks = 0;
    int           errors = 0;
    exp_t         sb[$];
    logic [511:0] model [DEPTH];

    main_mem_responder #(
        .DEPTH_BLOCKS  (DEPTH),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_read_req  (mem_read_req),
        .mem_write_req (mem_write_req),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .busy          (busy),
        .protocol_err  (protocol_err)
    );

    always #5 clk = ~clk;

    // Cycle count, read only on falling edges
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request for one cycle; optionally record the expected completion
    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit track);
        exp_t        e;
        int unsigned blk;
        int unsigned wd;
        blk = int'(addr[13:6]);
        wd  = int'(addr[5:2]);
        @(negedge clk);
        mem_addr      = addr;
        mem_wdata     = wdata;
        mem_read_req  = rd;
        mem_write_req = wr;
        if (track) begin
            if (rd) begin
                e.is_read = 1'b1;
                e.due     = cyc + 1 + RL;
                e.data    = model[blk];
                sb.push_back(e);
            end else if (wr) begin
                e.is_read = 1'b0;
                e.due     = cyc + 1 + WL;
                e.data    = '0;
                model[blk][wd*32 +: 32] = wdata;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
    endtask

    // Wait (bounded) for mem_ready and score it against the oldest expectation
    task automatic wait_resp(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (mem_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 512'(mem_ready), 512'(1));
        if (mem_ready === 1'b1) begin
            chk({tag, "_sb_nonempty"}, 512'(sb.size() > 0), 512'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_latency"}, 512'(cyc), 512'(e.due));
                if (e.is_read) chk({tag, "_rdata"}, mem_rdata, e.data);
            end
        end
    endtask

    // Count mem_ready pulses over n cycles; none are expected
    task automatic watch_quiet(input int n, input string tag);
        int pulses;
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (mem_ready === 1'b1) pulses++;
        end
        chk({tag, "_no_ready"}, 512'(pulses), 512'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        logic [511:0] blk5;
        rst_n         = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        for (int b = 0; b < int'(DEPTH); b++) begin
            for (int k = 0; k < 16; k++) begin
                model[b][k*32 +: 32] = (b == 5) ? 32'(k) : {16'(b), 16'(k)};
            end
            dut.u_ram.mem[b] = model[b];
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", 512'(mem_ready), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_err", 512'(protocol_err), 512'(0));
        chk("rst_rdata", mem_rdata, '0);
        rst_n = 1'b1;

        // Plain block read
        issue(1'b1, 1'b0, 32'h0000_0140, 32'h0, 1'b1);
        chk("rd_busy", 512'(busy), 512'(1));
        wait_resp("rd5");
        chk("rd5_word3", 512'(mem_rdata[3*32 +: 32]), 512'(32'h3));

        // Word write then back-to-back read of the same block
        issue(1'b0, 1'b1, 32'h0000_0148, 32'hDEAD_BEEF, 1'b1);
        wait_resp("wr5");
        issue(1'b1, 1'b0, 32'h0000_0140, 32'h0, 1'b1);
        wait_resp("rd5_after_wr");
        blk5 = model[5];
        chk("rd5_word2", 512'(mem_rdata[2*32 +: 32]), 512'(32'hDEAD_BEEF));
        chk("rd5_word1", 512'(mem_rdata[1*32 +: 32]), 512'(32'h1));
        chk("err_clean", 512'(protocol_err), 512'(0));
        chk("hold_rdata", mem_rdata, blk5);

        // Read and write together: read wins, write dropped
        issue(1'b1, 1'b1, 32'h0000_0148, 32'h1234_5678, 1'b1);
        wait_resp("rdwr");
        chk("rdwr_err", 512'(protocol_err), 512'(1));
        issue(1'b1, 1'b0, 32'h0000_0140, 32'h0, 1'b1);
        wait_resp("rdwr_verify");
        chk("rdwr_unchanged", mem_rdata, blk5);
        chk("err_sticky", 512'(protocol_err), 512'(1));

        // Request pulsed while busy is ignored
        do_reset();
        chk("err_cleared", 512'(protocol_err), 512'(0));
        issue(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 32'h0000_0140, 32'h0, 1'b0);
        wait_resp("rd8_single");
        watch_quiet(8, "rd8_single");
        chk("busy_req_err", 512'(protocol_err), 512'(1));
        chk("idle_busy", 512'(busy), 512'(0));

        // Reset two cycles into a read abandons it
        do_reset();
        issue(1'b1, 1'b0, 32'h0000_0140, 32'h0, 1'b0);
        @(negedge clk);
        do_reset();
        chk("abort_rd_busy", 512'(busy), 512'(0));
        chk("abort_rd_err", 512'(protocol_err), 512'(0));
        chk("abort_rd_rdata", mem_rdata, '0);
        watch_quiet(8, "abort_rd");

        // Reset during a write leaves storage untouched
        issue(1'b0, 1'b1, 32'h0000_024C, 32'hCAFE_F00D, 1'b0);
        do_reset();
        watch_quiet(4, "abort_wr");
        issue(1'b1, 1'b0, 32'h0000_0240, 32'h0, 1'b1);
        wait_resp("abort_wr_verify");
        chk("abort_wr_word3", 512'(mem_rdata[3*32 +: 32]), 512'(32'h0009_0003));

        // High address bits wrap onto the same block
        issue(1'b1, 1'b0, 32'h0001_0140, 32'h0, 1'b1);
        wait_resp("wrap");
        chk("wrap_data", mem_rdata, blk5);

        // Low address bits ignored on write; word 0 of block 8
        issue(1'b0, 1'b1, 32'h0000_0203, 32'h5A5A_A5A5, 1'b1);
        wait_resp("wr8");
        issue(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b1);
        wait_resp("rd8_verify");
        chk("rd8_word0", 512'(mem_rdata[31:0]), 512'(32'h5A5A_A5A5));
        chk("sb_drained", 512'(sb.size()), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
